// File: rtl/bound_flasher_sequencer.sv
// Bound flasher sequencer: runs the six-phase lamp sweep on a flick request, with
// optional kickback on flick while sweeping up through lamp 5 or lamp 10.
`timescale 1ns/1ps
module bound_flasher_sequencer #(
  parameter int unsigned STEP_DIV    = 1,     // clock cycles per lamp step, must be >= 1
  parameter bit          KICKBACK_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flick,
  output logic [15:0] lamp,
  output logic [2:0]  state,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   PW      = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] TickMax = PW'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StUp5     = 3'd1,
    StDn0     = 3'd2,
    StUp10    = 3'd3,
    StDn5     = 3'd4,
    StUp15    = 3'd5,
    StDn0F    = 3'd6,
    StIllegal = 3'd7
  } state_t;

  state_t         r_state, w_state_d, w_phase;
  logic [15:0]    r_lamp, w_lamp_d, w_step;
  logic [PW-1:0]  r_presc, w_presc_d;
  logic           r_done, w_done_d;
  logic           w_tick, w_up, w_kick;

  function automatic logic exit_hit(input state_t s, input logic [15:0] v);
    case (s)
      StUp5:         return v == 16'h003F;
      StDn0, StDn0F: return v == 16'h0000;
      StUp10:        return v == 16'h07FF;
      StDn5:         return v == 16'h001F;
      StUp15:        return v == 16'hFFFF;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      StUp5:   return StDn0;
      StDn0:   return StUp10;
      StUp10:  return StDn5;
      StDn5:   return StUp15;
      StUp15:  return StDn0F;
      default: return StIdle;
    endcase
  endfunction

  always_comb begin
    w_tick = (r_presc == TickMax);
    w_up   = (r_state == StUp5) || (r_state == StUp10) || (r_state == StUp15);
    w_kick = KICKBACK_EN && flick && w_tick &&
             ((r_state == StUp10) || (r_state == StUp15)) &&
             ((r_lamp == 16'h003F) || (r_lamp == 16'h07FF));

    w_phase   = r_state;
    w_step    = r_lamp;
    w_state_d = r_state;
    w_lamp_d  = r_lamp;
    w_presc_d = r_presc;
    w_done_d  = 1'b0;

    case (r_state)
      StIdle: begin
        w_presc_d = '0;
        if (flick) begin
          w_state_d = StUp5;
          w_lamp_d  = 16'h0001;
        end
      end
      StUp5, StDn0, StUp10, StDn5, StUp15, StDn0F: begin
        w_presc_d = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          if (w_kick) begin
            // Kickback turns the sweep around and is then judged as a down step.
            w_phase = (r_state == StUp10) ? StDn0 : StDn5;
            w_step  = {1'b0, r_lamp[15:1]};
          end else if (w_up) begin
            w_step = {r_lamp[14:0], 1'b1};
          end else begin
            w_step = {1'b0, r_lamp[15:1]};
          end
          w_lamp_d  = w_step;
          w_state_d = w_phase;
          if (exit_hit(w_phase, w_step)) begin
            w_state_d = next_phase(w_phase);
            w_done_d  = (w_phase == StDn0F);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_lamp_d  = '0;
        w_presc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_lamp  <= '0;
      r_presc <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_lamp  <= w_lamp_d;
      r_presc <= w_presc_d;
      r_done  <= w_done_d;
    end
  end

  assign lamp  = r_lamp;
  assign state = r_state;
  assign busy  = (r_state != StIdle);
  assign done  = r_done;

endmodule

// File: tb/tb_bound_flasher_sequencer.sv
// Bench for bound_flasher_sequencer: three instances (fast, STEP_DIV=4, no kickback)
// checked against a lamp-count model of the sweep.
`timescale 1ns/1ps
module tb_bound_flasher_sequencer;

  logic        clk;
  logic        rst;
  logic        flick_i [3];
  logic [15:0] lamp_o  [3];
  logic [2:0]  state_o [3];
  logic        busy_o  [3];
  logic        done_o  [3];

  int vectors;
  int miscompares;

  bound_flasher_sequencer #(.STEP_DIV(1), .KICKBACK_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .flick(flick_i[0]), .lamp(lamp_o[0]), .state(state_o[0]),
    .busy(busy_o[0]), .done(done_o[0]));
  bound_flasher_sequencer #(.STEP_DIV(4), .KICKBACK_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .flick(flick_i[1]), .lamp(lamp_o[1]), .state(state_o[1]),
    .busy(busy_o[1]), .done(done_o[1]));
  bound_flasher_sequencer #(.STEP_DIV(1), .KICKBACK_EN(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .flick(flick_i[2]), .lamp(lamp_o[2]), .state(state_o[2]),
    .busy(busy_o[2]), .done(done_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: phase number (0 idle, odd = sweeping up, even = sweeping down),
  // number of lit lamps, and cycles elapsed within the current step.
  int m_stage [3];
  int m_n     [3];
  int m_cnt   [3];
  bit m_done  [3];
  int div_c   [3] = '{1, 4, 1};
  bit kb_c    [3] = '{1'b1, 1'b1, 1'b0};

  function automatic int target(input int s);
    case (s)
      1: return 6;
      3: return 11;
      4: return 5;
      5: return 16;
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] mlamp(input int k);
    int v;
    v = (1 << m_n[k]) - 1;
    return v[15:0];
  endfunction

  function automatic logic [20:0] exp_vec(input int k);
    return {mlamp(k), 3'(m_stage[k]), m_stage[k] != 0, m_done[k]};
  endfunction

  function automatic logic [20:0] obs_vec(input int k);
    return {lamp_o[k], state_o[k], busy_o[k], done_o[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_stage[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_done[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input bit f);
    bit tk;
    int s;
    m_done[k] = 1'b0;
    if (m_stage[k] == 0) begin
      if (f) begin
        m_stage[k] = 1; m_n[k] = 1; m_cnt[k] = 0;
      end
    end else begin
      tk = (m_cnt[k] == div_c[k] - 1);
      m_cnt[k] = tk ? 0 : m_cnt[k] + 1;
      if (tk) begin
        s = m_stage[k];
        if (kb_c[k] && f && (s == 3 || s == 5) && (m_n[k] == 6 || m_n[k] == 11)) begin
          m_n[k] = m_n[k] - 1;
          s = (s == 3) ? 2 : 4;
        end else if (s % 2 == 1) begin
          m_n[k] = m_n[k] + 1;
        end else begin
          m_n[k] = m_n[k] - 1;
        end
        if (m_n[k] == target(s)) begin
          if (s == 6) begin
            s = 0;
            m_done[k] = 1'b1;
          end else begin
            s = s + 1;
          end
        end
        m_stage[k] = s;
      end
    end
  endtask

  // Drive flicks away from the edge, clock once, advance the model, settle.
  task automatic step(input bit f0, input bit f1, input bit f2);
    @(negedge clk);
    flick_i[0] = f0; flick_i[1] = f1; flick_i[2] = f2;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_edge(0, f0); model_edge(1, f1); model_edge(2, f2);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    flick_i[0] = 1'b0; flick_i[1] = 1'b0; flick_i[2] = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (obs_vec(k) !== 21'h0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d got=%h want=%h", k, obs_vec(k), 21'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    for (int e = 1; e <= 20; e++) step(e == 1, 1'b0, 1'b0);
    vectors++;
    if (lamp_o[0] !== 16'h00FF) begin
      miscompares++;
      $display("FAIL mid_reset_pre got=%h want=%h", lamp_o[0], 16'h00FF);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (lamp_o[0] !== 16'h0000 || state_o[0] !== 3'd0 || busy_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_async got=%h/%0d/%b want=0000/0/0",
               lamp_o[0], state_o[0], busy_o[0]);
    end
    for (int e = 0; e < 3; e++) begin
      step(1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== 21'h0) begin
          miscompares++;
          $display("FAIL reset_hold dut%0d got=%h want=%h", k, obs_vec(k), 21'h0);
        end
      end
    end
    @(negedge clk);
    flick_i[0] = 1'b0; flick_i[1] = 1'b0; flick_i[2] = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_full_sweep();
    int          ce [7] = '{1, 6, 12, 23, 29, 40, 56};
    logic [15:0] cl [7] = '{16'h0001, 16'h003F, 16'h0000, 16'h07FF, 16'h001F, 16'hFFFF, 16'h0000};
    logic [2:0]  cs [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    do_reset();
    for (int e = 1; e <= 57; e++) begin
      step(e == 1, 1'b0, 1'b0);
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL sweep e=%0d got=%h want=%h", e, obs_vec(0), exp_vec(0));
      end
      for (int i = 0; i < 7; i++) begin
        if (ce[i] == e) begin
          vectors++;
          if (lamp_o[0] !== cl[i] || state_o[0] !== cs[i] || done_o[0] !== (e == 56)) begin
            miscompares++;
            $display("FAIL sweep_point e=%0d got=%h/%0d/%b want=%h/%0d/%b",
                     e, lamp_o[0], state_o[0], done_o[0], cl[i], cs[i], e == 56);
          end
        end
      end
    end
    vectors++;
    if (done_o[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL done_one_cycle got=%b want=0", done_o[0]);
    end
  endtask

  task automatic test_kickback_up10();
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      step(e == 1 || e == 19, 1'b0, 1'b0);
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL kick10 e=%0d got=%h want=%h", e, obs_vec(0), exp_vec(0));
      end
      if (e == 19 || e == 24) begin
        vectors++;
        if (lamp_o[0] !== ((e == 19) ? 16'h001F : 16'h0000) ||
            state_o[0] !== ((e == 19) ? 3'd2 : 3'd3)) begin
          miscompares++;
          $display("FAIL kick10_point e=%0d got=%h/%0d", e, lamp_o[0], state_o[0]);
        end
      end
    end
  endtask

  task automatic test_kickback_up15();
    do_reset();
    for (int e = 1; e <= 44; e++) begin
      step(e == 1 || e == 36 || e == 43, 1'b0, 1'b0);
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL kick15 e=%0d got=%h want=%h", e, obs_vec(0), exp_vec(0));
      end
      if (e == 36 || e == 43) begin
        vectors++;
        if (lamp_o[0] !== ((e == 36) ? 16'h03FF : 16'h001F) ||
            state_o[0] !== ((e == 36) ? 3'd4 : 3'd5)) begin
          miscompares++;
          $display("FAIL kick15_point e=%0d got=%h/%0d", e, lamp_o[0], state_o[0]);
        end
      end
    end
  endtask

  task automatic test_step_div4();
    bit f;
    do_reset();
    for (int e = 1; e <= 222; e++) begin
      // Flick only on cycles that are not ticks, which must never kick back.
      f = (e == 1) || (m_stage[1] != 0 && m_cnt[1] != 3);
      step(1'b0, f, 1'b0);
      vectors++;
      if (obs_vec(1) !== exp_vec(1)) begin
        miscompares++;
        $display("FAIL div4 e=%0d got=%h want=%h", e, obs_vec(1), exp_vec(1));
      end
      if (e == 4 || e == 5) begin
        vectors++;
        if (lamp_o[1] !== ((e == 4) ? 16'h0001 : 16'h0003)) begin
          miscompares++;
          $display("FAIL div4_step e=%0d got=%h", e, lamp_o[1]);
        end
      end
      if (e == 221) begin
        vectors++;
        if (done_o[1] !== 1'b1 || state_o[1] !== 3'd0) begin
          miscompares++;
          $display("FAIL div4_done got=%b/%0d want=1/0", done_o[1], state_o[1]);
        end
      end
    end
  endtask

  task automatic test_no_kickback();
    do_reset();
    for (int e = 1; e <= 57; e++) begin
      step(1'b0, 1'b0, 1'b1);
      vectors++;
      if (obs_vec(2) !== exp_vec(2)) begin
        miscompares++;
        $display("FAIL nokick e=%0d got=%h want=%h", e, obs_vec(2), exp_vec(2));
      end
      if (e == 19 || e == 56 || e == 57) begin
        vectors++;
        if (lamp_o[2] !== ((e == 19) ? 16'h007F : (e == 56) ? 16'h0000 : 16'h0001) ||
            state_o[2] !== ((e == 19) ? 3'd3 : (e == 56) ? 3'd0 : 3'd1) ||
            done_o[2] !== (e == 56)) begin
          miscompares++;
          $display("FAIL nokick_point e=%0d got=%h/%0d/%b", e, lamp_o[2], state_o[2], done_o[2]);
        end
      end
    end
  endtask

  task automatic test_held_high();
    do_reset();
    for (int e = 1; e <= 60; e++) begin
      step(1'b1, 1'b0, 1'b0);
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL held e=%0d got=%h want=%h", e, obs_vec(0), exp_vec(0));
      end
      if (e == 19) begin
        vectors++;
        if (lamp_o[0] !== 16'h001F || state_o[0] !== 3'd2) begin
          miscompares++;
          $display("FAIL held_kick got=%h/%0d want=001f/2", lamp_o[0], state_o[0]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int e = 1; e <= 58; e++) begin
      step(e == 1 || e >= 55, 1'b0, 1'b0);
      vectors++;
      if (obs_vec(0) !== exp_vec(0)) begin
        miscompares++;
        $display("FAIL b2b e=%0d got=%h want=%h", e, obs_vec(0), exp_vec(0));
      end
      if (e == 56 || e == 57) begin
        vectors++;
        if (lamp_o[0] !== ((e == 56) ? 16'h0000 : 16'h0001) ||
            state_o[0] !== ((e == 56) ? 3'd0 : 3'd1) || done_o[0] !== (e == 56)) begin
          miscompares++;
          $display("FAIL b2b_point e=%0d got=%h/%0d/%b", e, lamp_o[0], state_o[0], done_o[0]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int e = 0; e < 1500; e++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (obs_vec(k) !== exp_vec(k)) begin
          miscompares++;
          $display("FAIL random e=%0d dut%0d got=%h want=%h", e, k, obs_vec(k), exp_vec(k));
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
          vectors++;
          if (obs_vec(k) !== 21'h0) begin
            miscompares++;
            $display("FAIL random_reset dut%0d got=%h want=%h", k, obs_vec(k), 21'h0);
          end
        end
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    flick_i[0] = 1'b0; flick_i[1] = 1'b0; flick_i[2] = 1'b0;
    model_reset();
    test_reset();
    test_reset_mid_sweep();
    test_full_sweep();
    test_kickback_up10();
    test_kickback_up15();
    test_step_div4();
    test_no_kickback();
    test_held_high();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
